mem_access_unit: RTL and testbench

Multi-cycle data-memory access stage sitting directly downstream of the execute stage in the LEGv8 pipeline. It consumes the execute-stage ALU result as an address and the second register operand as store data, then drives a request/acknowledge handshake to the data memory for LDUR/STUR. It stalls the pipeline while the access is outstanding and returns load data to writeback. It also reports timeouts and illegal requests as sticky faults.

---
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// LEGv8 data-memory access stage: req/ack handshake for LDUR/STUR with pipeline stall and sticky faults.
// Optional alignment check enabled by defining MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int WORD           = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [WORD-1:0] address,
    input  logic [WORD-1:0] write_data,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [WORD-1:0] dmem_addr,
    output logic [WORD-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [WORD-1:0] dmem_rdata,
    output logic [WORD-1:0] read_data,
    output logic            done,
    output logic            stall,
    output logic            fault,
    output logic [1:0]      fault_code
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        FAULT
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [WORD-1:0] addr_q, addr_d;
    logic [WORD-1:0] wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [WORD-1:0] read_data_q, read_data_d;
    logic [1:0]      fault_code_q, fault_code_d;

    logic idle_or_done;
    logic accept;
    logic illegal;
    logic misaligned;

    assign idle_or_done = (state_q == IDLE) || (state_q == DONE);
    assign accept       = in_valid && (mem_read != mem_write);
    assign illegal      = in_valid && mem_read && mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = (address[2:0] != 3'b000);
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        read_data_d  = read_data_q;
        fault_code_d = fault_code_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                // Illegal flag combination outranks the alignment fault.
                if (illegal) begin
                    state_d      = FAULT;
                    fault_code_d = 2'b11;
                end else if (accept) begin
                    if (misaligned) begin
                        state_d      = FAULT;
                        fault_code_d = 2'b10;
                    end else begin
                        state_d = ACCESS;
                        cnt_d   = 8'd0;
                        addr_d  = address;
                        wdata_d = write_data;
                        we_d    = mem_write;
                    end
                end
            end
            ACCESS: begin
                // An ack in the last allowed cycle still completes the access.
                if (dmem_ack) begin
                    state_d = DONE;
                    if (!we_q) begin
                        read_data_d = dmem_rdata;
                    end
                end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
                    state_d      = FAULT;
                    fault_code_d = 2'b01;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 8'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            read_data_q  <= '0;
            fault_code_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            read_data_q  <= read_data_d;
            fault_code_q <= fault_code_d;
        end
    end

    assign dmem_req   = (state_q == ACCESS);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign read_data  = read_data_q;
    assign done       = (state_q == DONE);
    assign fault      = (state_q == FAULT);
    assign fault_code = fault_code_q;
    assign stall      = (state_q == ACCESS) || (state_q == FAULT) || (idle_or_done && accept);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;

    localparam int WORD = 64;

    logic            clk;
    logic            rst_n;
    logic            in_valid;
    logic            mem_read;
    logic            mem_write;
    logic [WORD-1:0] address;
    logic [WORD-1:0] write_data;
    logic            dmem_req;
    logic            dmem_we;
    logic [WORD-1:0] dmem_addr;
    logic [WORD-1:0] dmem_wdata;
    logic            dmem_ack;
    logic [WORD-1:0] dmem_rdata;
    logic [WORD-1:0] read_data;
    logic            done;
    logic            stall;
    logic            fault;
    logic [1:0]      fault_code;

    int total;
    int bad;

    mem_access_unit #(
        .TIMEOUT_CYCLES(4),
        .WORD(WORD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .mem_read(mem_read),
        .mem_write(mem_write),
        .address(address),
        .write_data(write_data),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata),
        .read_data(read_data),
        .done(done),
        .stall(stall),
        .fault(fault),
        .fault_code(fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [WORD-1:0] got, input logic [WORD-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic r, input logic w,
                                 input logic [WORD-1:0] a, input logic [WORD-1:0] wd);
        in_valid   = v;
        mem_read   = r;
        mem_write  = w;
        address    = a;
        write_data = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        doReset();

        checkOutput("rst_req", WORD'(dmem_req), 0);
        checkOutput("rst_done", WORD'(done), 0);
        checkOutput("rst_stall", WORD'(stall), 0);
        checkOutput("rst_fault", WORD'(fault), 0);
        checkOutput("rst_code", WORD'(fault_code), 0);
        checkOutput("rst_rdata", read_data, 0);
        checkOutput("rst_addr", dmem_addr, 0);

        // Load 0x100 acked in the third request cycle
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h100, 64'h0);
        #1;
        checkOutput("ld_accept_stall", WORD'(stall), 1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("ld_req1", WORD'(dmem_req), 1);
        checkOutput("ld_we", WORD'(dmem_we), 0);
        checkOutput("ld_addr", dmem_addr, 64'h100);
        tick();
        checkOutput("ld_req2", WORD'(dmem_req), 1);
        tick();
        checkOutput("ld_req3", WORD'(dmem_req), 1);
        checkOutput("ld_done_early", WORD'(done), 0);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hDEADBEEF;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        checkOutput("ld_done", WORD'(done), 1);
        checkOutput("ld_done_req", WORD'(dmem_req), 0);
        checkOutput("ld_done_stall", WORD'(stall), 0);
        checkOutput("ld_rdata", read_data, 64'hDEADBEEF);
        tick();
        checkOutput("ld_done_pulse", WORD'(done), 0);

        // Store then back-to-back load presented in the DONE cycle
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h108, 64'h55);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("st_req", WORD'(dmem_req), 1);
        checkOutput("st_we", WORD'(dmem_we), 1);
        checkOutput("st_addr", dmem_addr, 64'h108);
        checkOutput("st_wdata", dmem_wdata, 64'h55);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        checkOutput("st_done", WORD'(done), 1);
        checkOutput("st_gap_req", WORD'(dmem_req), 0);
        checkOutput("st_rdata_kept", read_data, 64'hDEADBEEF);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h110, 64'h0);
        #1;
        checkOutput("b2b_stall", WORD'(stall), 1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("b2b_req", WORD'(dmem_req), 1);
        checkOutput("b2b_we", WORD'(dmem_we), 0);
        checkOutput("b2b_addr", dmem_addr, 64'h110);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h123456789ABCDEF0;
        tick();
        dmem_ack = 1'b0;
        checkOutput("b2b_done", WORD'(done), 1);
        checkOutput("b2b_rdata", read_data, 64'h123456789ABCDEF0);
        tick();

        // Ack in the fourth (last allowed) request cycle
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h200, 64'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        tick();
        checkOutput("last_req4", WORD'(dmem_req), 1);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hCAFE;
        tick();
        dmem_ack = 1'b0;
        checkOutput("last_done", WORD'(done), 1);
        checkOutput("last_fault", WORD'(fault), 0);
        checkOutput("last_rdata", read_data, 64'hCAFE);
        tick();

        // Ack outside ACCESS and a flagless in_valid are both no-ops
        dmem_ack   = 1'b1;
        dmem_rdata = 64'hBAD;
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h300, 64'h0);
        #1;
        checkOutput("noop_stall", WORD'(stall), 0);
        tick();
        dmem_ack = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("noop_req", WORD'(dmem_req), 0);
        checkOutput("noop_done", WORD'(done), 0);
        checkOutput("noop_rdata", read_data, 64'hCAFE);

        // Address 0x104: normal access, or an alignment fault when checking is on
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h104, 64'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
`ifdef MEM_ALIGN_CHECK_EN
        checkOutput("mis_fault", WORD'(fault), 1);
        checkOutput("mis_code", WORD'(fault_code), 2);
        checkOutput("mis_req", WORD'(dmem_req), 0);
        doReset();
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h105, 64'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("mis_ill_code", WORD'(fault_code), 3);
        doReset();
`else
        checkOutput("mis_req", WORD'(dmem_req), 1);
        checkOutput("mis_addr", dmem_addr, 64'h104);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h7777;
        tick();
        dmem_ack = 1'b0;
        checkOutput("mis_done", WORD'(done), 1);
        checkOutput("mis_rdata", read_data, 64'h7777);
        tick();
`endif

        // Illegal request: both flags set
        applyStimulus(1'b1, 1'b1, 1'b1, 64'h500, 64'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("ill_fault", WORD'(fault), 1);
        checkOutput("ill_code", WORD'(fault_code), 3);
        checkOutput("ill_req", WORD'(dmem_req), 0);
        checkOutput("ill_stall", WORD'(stall), 1);
        doReset();

        // Timeout with no ack
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h400, 64'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        tick();
        checkOutput("to_req4", WORD'(dmem_req), 1);
        checkOutput("to_no_fault_yet", WORD'(fault), 0);
        tick();
        checkOutput("to_fault", WORD'(fault), 1);
        checkOutput("to_code", WORD'(fault_code), 1);
        checkOutput("to_stall", WORD'(stall), 1);
        checkOutput("to_req", WORD'(dmem_req), 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h408, 64'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("to_sticky", WORD'(fault), 1);
        checkOutput("to_sticky_stall", WORD'(stall), 1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("to_rst_fault", WORD'(fault), 0);
        checkOutput("to_rst_code", WORD'(fault_code), 0);
        checkOutput("to_rst_stall", WORD'(stall), 0);
        tick();
        rst_n = 1'b1;

        // Reset pulled mid-access after a completed load
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h600, 64'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        dmem_ack   = 1'b1;
        dmem_rdata = 64'h9999;
        tick();
        dmem_ack = 1'b0;
        checkOutput("mid_pre_rdata", read_data, 64'h9999);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 64'h608, 64'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
        checkOutput("mid_req", WORD'(dmem_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_req", WORD'(dmem_req), 0);
        checkOutput("mid_rst_stall", WORD'(stall), 0);
        checkOutput("mid_rst_done", WORD'(done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("mid_after_req", WORD'(dmem_req), 0);
        checkOutput("mid_after_stall", WORD'(stall), 0);
        checkOutput("mid_after_rdata", read_data, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
